// File: rtl/ropuf_pkg.sv
// ropuf_pkg -- shared types and defaults for the ring-oscillator PUF sequencer.
//
// Contents:
//   state_e   : sequencer states (IDLE, SETTLE, COUNT, COMPARE, DONE)
//   DEF_*     : default parameter values used by ro_puf_ctrl
//   MEAS_REP  : measurements taken per oscillator pair. This is 3 (majority vote)
//               when RO_PUF_MAJORITY_EN is defined and 1 otherwise.
package ropuf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_COMPARE,
    ST_DONE
  } state_e;

  localparam int DEF_N_RO      = 16;
  localparam int DEF_SEL_W     = 4;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_WINDOW    = 1024;
  localparam int DEF_SETTLE    = 8;
  localparam int DEF_RESP_BITS = 8;

`ifdef RO_PUF_MAJORITY_EN
  localparam int MEAS_REP = 3;
`else
  localparam int MEAS_REP = 1;
`endif

endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter -- counts rising edges of an asynchronous oscillator signal.
//
// The ro input passes through a 2-flop synchroniser. A rising-edge detector
// follows the synchroniser, and a saturating counter follows the detector.
//
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   ro       : asynchronous oscillator input
//   en       : count detected edges while high
//   clr      : synchronous clear (has priority over en)
//   cnt      : edge count; holds at all-ones once saturated
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbour (the synchroniser chain depends
  // on this).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ro};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && rise && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl -- sequencer for the ring-oscillator PUF.
//
// For each response bit i, the sequencer selects oscillator pair
// (2i ^ chal, 2i+1 ^ chal) on muxes A and B. It then waits SETTLE cycles,
// counts rising edges of both mux outputs for WINDOW cycles, and sets
// response[i] = (count_a > count_b). Equal counts give a 0 bit and set the
// sticky tie flag.
// When RO_PUF_MAJORITY_EN is defined, each pair is measured three times and
// response[i] is the majority of the three comparisons.
//
// Ports:
//   clk, rst       : system clock, asynchronous active-high reset
//   start          : one-cycle run request, accepted in IDLE only
//   challenge      : XOR mask on pair indices, latched on an accepted start
//   ro_a, ro_b     : asynchronous outputs of RO muxes A and B
//   sel_a, sel_b   : mux selects; these hold their last value in IDLE
//   ro_en          : ring-oscillator enable
//   busy           : run in progress
//   done           : one-cycle pulse when response/tie are valid
//   response       : response word, bit i from pair i
//   tie            : some pair measured equal counts during the last run
module ro_puf_ctrl
  import ropuf_pkg::*;
#(
  parameter int N_RO      = DEF_N_RO,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int RESP_BITS = DEF_RESP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SEL_W-1:0]     challenge,
  input  logic                 ro_a,
  input  logic                 ro_b,
  output logic [SEL_W-1:0]     sel_a,
  output logic [SEL_W-1:0]     sel_b,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 tie
);

  // A pair index needs one bit fewer than a select: sel = {pair, a/b} ^ chal.
  localparam int PAIR_W  = $clog2(N_RO / 2);
  localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [1:0] VOTE_MIN = 2'((MEAS_REP + 1) / 2);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   chal_q;
  logic [PAIR_W-1:0]  pair_q;
  logic [PAIR_W-1:0]  pair_inc;
  logic [1:0]         rep_q;
  logic [1:0]         votes_q;
  logic [1:0]         vote_total;
  logic [TMR_W-1:0]   tmr_q;
  logic [CNT_W-1:0]   cnt_a, cnt_b;
  logic               cnt_en, cnt_clr;
  logic               settle_end, window_end, last_pair, last_rep;
  logic               cmp_bit, cmp_tie, maj_bit;

  // ---------------------------------------------------------------- counters
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk (clk),
    .rst (rst),
    .ro  (ro_a),
    .en  (cnt_en),
    .clr (cnt_clr),
    .cnt (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk (clk),
    .rst (rst),
    .ro  (ro_b),
    .en  (cnt_en),
    .clr (cnt_clr),
    .cnt (cnt_b)
  );

  // ---------------------------------------------------------------- decodes
  assign settle_end = (tmr_q == TMR_W'(SETTLE - 1));
  assign window_end = (tmr_q == TMR_W'(WINDOW - 1));
  assign last_pair  = (pair_q == PAIR_W'(RESP_BITS - 1));
  assign last_rep   = (rep_q == 2'(MEAS_REP - 1));
  assign pair_inc   = pair_q + PAIR_W'(1);

  // Saturated counters compare equal, so two saturated counts are a tie.
  assign cmp_bit    = (cnt_a > cnt_b);
  assign cmp_tie    = (cnt_a == cnt_b);
  assign vote_total = votes_q + {1'b0, cmp_bit};
  assign maj_bit    = (vote_total >= VOTE_MIN);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SETTLE;
      ST_SETTLE:  if (settle_end) state_d = ST_COUNT;
      ST_COUNT:   if (window_end) state_d = ST_COMPARE;
      ST_COMPARE: state_d = (last_rep && last_pair) ? ST_DONE : ST_SETTLE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    ro_en   = 1'b0;
    done    = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b1;
    case (state_q)
      ST_SETTLE:  begin busy = 1'b1; ro_en = 1'b1; end
      ST_COUNT:   begin busy = 1'b1; ro_en = 1'b1; cnt_en = 1'b1; cnt_clr = 1'b0; end
      // The counts are still read in COMPARE. The clear takes effect at the end
      // of this cycle.
      ST_COMPARE: begin busy = 1'b1; ro_en = 1'b1; end
      ST_DONE:    begin busy = 1'b1; done = 1'b1; end
      default:    ;
    endcase
  end

  // Phase timer: restarts on every state change and measures SETTLE/COUNT length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else if (state_d != state_q) begin
      tmr_q <= '0;
    end else if (state_q == ST_SETTLE || state_q == ST_COUNT) begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chal_q   <= '0;
      pair_q   <= '0;
      rep_q    <= '0;
      votes_q  <= '0;
      sel_a    <= '0;
      sel_b    <= '0;
      response <= '0;
      tie      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            chal_q   <= challenge;
            pair_q   <= '0;
            rep_q    <= '0;
            votes_q  <= '0;
            sel_a    <= challenge;
            sel_b    <= challenge ^ SEL_W'(1);
            response <= '0;
            tie      <= 1'b0;
          end
        end
        ST_COMPARE: begin
          if (cmp_tie) tie <= 1'b1;
          if (last_rep) begin
            for (int b = 0; b < RESP_BITS; b++) begin
              if (PAIR_W'(b) == pair_q) response[b] <= maj_bit;
            end
            rep_q   <= '0;
            votes_q <= '0;
            if (!last_pair) begin
              pair_q <= pair_inc;
              sel_a  <= SEL_W'({pair_inc, 1'b0}) ^ chal_q;
              sel_b  <= SEL_W'({pair_inc, 1'b1}) ^ chal_q;
            end
          end else begin
            rep_q   <= rep_q + 2'd1;
            votes_q <= vote_total;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb_ro_puf_ctrl -- self-checking bench for ro_puf_ctrl.
//
// The bench models sixteen ring oscillators as square waves. Each has a
// half-period hp[k] that is randomised per run, and the waves are computed
// from absolute simulation time. The mux outputs follow the DUT selects.
// The reference model derives each expected bit from the oscillator
// frequencies: the faster oscillator on side A gives 1, and equal half-periods
// give a tie.
// Equal half-periods produce identical waveforms, so those counts tie exactly.
//
// Latency is counted in clock cycles. The count starts at the cycle in which
// start is high and includes the cycle in which done is high.
//
// A second, small instance with 3-bit counters checks saturation.
module tb_ro_puf_ctrl;

`ifdef RO_PUF_MAJORITY_EN
  localparam int REP = 3;
`else
  localparam int REP = 1;
`endif
  localparam int MAIN_LAT = 1 + 8 * REP * (8 + 1024 + 1) + 1;
  localparam int SAT_LAT  = 1 + 2 * REP * (2 + 40 + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // main instance (default parameters)
  logic       start = 1'b0;
  logic [3:0] challenge = '0;
  logic       ro_a = 1'b0, ro_b = 1'b0;
  logic [3:0] sel_a, sel_b;
  logic       ro_en, busy, done, tie;
  logic [7:0] response;

  // saturation instance
  logic       s_start = 1'b0;
  logic [3:0] s_challenge = '0;
  logic       s_ro_a = 1'b0, s_ro_b = 1'b0;
  logic [3:0] s_sel_a, s_sel_b;
  logic       s_ro_en, s_busy, s_done, s_tie;
  logic [1:0] s_response;

  int hp[16];
  int n_tests = 0;
  int n_fail  = 0;

  ro_puf_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .challenge (challenge),
    .ro_a      (ro_a),
    .ro_b      (ro_b),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .ro_en     (ro_en),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .tie       (tie)
  );

  ro_puf_ctrl #(
    .N_RO(16), .SEL_W(4), .CNT_W(3), .WINDOW(40), .SETTLE(2), .RESP_BITS(2)
  ) u_sat (
    .clk       (clk),
    .rst       (rst),
    .start     (s_start),
    .challenge (s_challenge),
    .ro_a      (s_ro_a),
    .ro_b      (s_ro_b),
    .sel_a     (s_sel_a),
    .sel_b     (s_sel_b),
    .ro_en     (s_ro_en),
    .busy      (s_busy),
    .done      (s_done),
    .response  (s_response),
    .tie       (s_tie)
  );

  // ---------------------------------------------------------------- oscillators
  function automatic logic phase(input int h);
    longint t;
    t = longint'($time);
    return ((t / longint'(h)) % 2) != 0;
  endfunction

  // Updates happen at odd times. Clock edges fall on multiples of 10, so an
  // oscillator never changes on an active edge.
  initial begin
    #1;
    forever begin
      ro_a   = ro_en & phase(hp[sel_a]);
      ro_b   = ro_en & phase(hp[sel_b]);
      s_ro_a = s_ro_en & phase(hp[s_sel_a]);
      s_ro_b = s_ro_en & phase(hp[s_sel_b]);
      #2;
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // For each pair, sets which side oscillates faster under challenge chal.
  task automatic set_hp_pairs(input logic [3:0] chal, input bit a_fast);
    logic [3:0] a, b;
    int fast, slow;
    for (int i = 0; i < 8; i++) begin
      a    = 4'(2 * i) ^ chal;
      b    = 4'(2 * i + 1) ^ chal;
      fast = 26 + 4 * int'($urandom_range(0, 3));
      slow = fast + 4 + 4 * int'($urandom_range(0, 3));
      hp[a] = a_fast ? fast : slow;
      hp[b] = a_fast ? slow : fast;
    end
  endtask

  function automatic logic [7:0] model_resp(input logic [3:0] chal, input int n_pairs);
    logic [7:0] r;
    logic [3:0] a, b;
    r = '0;
    for (int i = 0; i < n_pairs; i++) begin
      a    = 4'(2 * i) ^ chal;
      b    = 4'(2 * i + 1) ^ chal;
      r[i] = hp[a] < hp[b];
    end
    return r;
  endfunction

  function automatic logic model_tie(input logic [3:0] chal);
    logic t;
    t = 1'b0;
    for (int i = 0; i < 8; i++)
      if (hp[4'(2 * i) ^ chal] == hp[4'(2 * i + 1) ^ chal]) t = 1'b1;
    return t;
  endfunction

  task automatic run_main(input string tag, input logic [3:0] chal,
                          input bit inject, input bit start_at_done);
    logic [7:0] exp_resp;
    logic       exp_tie;
    logic [7:0] seq[$];
    int         cyc;
    bit         got_done;
    exp_resp = model_resp(chal, 8);
    exp_tie  = model_tie(chal);
    @(negedge clk);
    start     = 1'b1;
    challenge = chal;
    cyc       = 1;
    got_done  = 1'b0;
    check({tag, "/busy_at_start"}, 32'(busy), 32'd0);
    while (!got_done && cyc < MAIN_LAT + 64) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (inject && cyc == 100) begin
        start     = 1'b1;
        challenge = ~chal;
      end
      if (cyc == 2) check({tag, "/busy_rise"}, 32'(busy), 32'd1);
      if (busy && ro_en && (seq.size() == 0 || seq[$] != {sel_a, sel_b}))
        seq.push_back({sel_a, sel_b});
      if (done) got_done = 1'b1;
    end
    check({tag, "/latency"}, 32'(cyc), 32'(MAIN_LAT));
    check({tag, "/response"}, 32'(response), 32'(exp_resp));
    check({tag, "/tie"}, 32'(tie), 32'(exp_tie));
    check({tag, "/ro_en_done"}, 32'(ro_en), 32'd0);
    check({tag, "/n_pairs"}, 32'(seq.size()), 32'd8);
    for (int i = 0; i < 8 && i < seq.size(); i++)
      check({tag, "/sel_pair"}, 32'(seq[i]), 32'({4'(2 * i) ^ chal, 4'(2 * i + 1) ^ chal}));
    if (start_at_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
    check({tag, "/busy_after"}, 32'(busy), 32'd0);
    check({tag, "/resp_hold"}, 32'(response), 32'(exp_resp));
    check({tag, "/tie_hold"}, 32'(tie), 32'(exp_tie));
    check({tag, "/sel_hold"}, 32'({sel_a, sel_b}), 32'({4'(14) ^ chal, 4'(15) ^ chal}));
    repeat (2) @(negedge clk);
    check({tag, "/stay_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_sat();
    int cyc;
    bit got_done;
    // pair 0: both sides saturate (tie, bit 0); pair 1: only A saturates (bit 1)
    hp[0] = 26; hp[1] = 30; hp[2] = 26; hp[3] = 400;
    @(negedge clk);
    s_start     = 1'b1;
    s_challenge = 4'h0;
    cyc         = 1;
    got_done    = 1'b0;
    while (!got_done && cyc < SAT_LAT + 64) begin
      @(negedge clk);
      cyc++;
      s_start = 1'b0;
      if (s_done) got_done = 1'b1;
    end
    check("sat/latency", 32'(cyc), 32'(SAT_LAT));
    check("sat/response", 32'(s_response), 32'b10);
    check("sat/tie", 32'(s_tie), 32'd1);
  endtask

  task automatic run_reset_mid();
    int cyc;
    int rst_at;
    logic [7:0] partial;
    rst_at = 2 + 2 * REP * 1033 + 8 + 100;  // inside COUNT of pair 2
    set_hp_pairs(4'h3, 1'b1);
    partial = model_resp(4'h3, 2);
    @(negedge clk);
    start     = 1'b1;
    challenge = 4'h3;
    cyc       = 1;
    while (cyc < rst_at) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    check("rst_mid/busy_before", 32'(busy), 32'd1);
    check("rst_mid/partial_resp", 32'(response), 32'(partial));
    check("rst_mid/sel_before", 32'({sel_a, sel_b}), 32'({4'(4) ^ 4'h3, 4'(5) ^ 4'h3}));
    rst = 1'b1;
    #1;
    check("rst_mid/outputs", 32'({sel_a, sel_b, ro_en, busy, done, response, tie}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid/idle_after", 32'({sel_a, sel_b, ro_en, busy, done, response, tie}), 32'd0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    for (int k = 0; k < 16; k++) hp[k] = 26;
    repeat (3) @(negedge clk);
    check("reset/sel_a", 32'(sel_a), 32'd0);
    check("reset/sel_b", 32'(sel_b), 32'd0);
    check("reset/ro_en", 32'(ro_en), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/response", 32'(response), 32'd0);
    check("reset/tie", 32'(tie), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_sat();

    set_hp_pairs(4'h0, 1'b1);
    run_main("a_fast", 4'h0, 1'b0, 1'b1);

    run_reset_mid();

    set_hp_pairs(4'h5, 1'b0);
    run_main("b_fast_busy_start", 4'h5, 1'b1, 1'b0);

`ifndef RO_PUF_MAJORITY_EN
    set_hp_pairs(4'h0, 1'b1);
    hp[7] = hp[6];
    run_main("tie_pair3", 4'h0, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) hp[k] = 26 + 4 * int'($urandom_range(0, 4));
    run_main("random", 4'($urandom_range(0, 15)), 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_puf_ctrl.md
Name: ro_puf_ctrl

Overview:
- Sequencer for the ring-oscillator PUF.
- Drives the select inputs of two 16:1 RO multiplexers (A and B) and gates the ROs.
- Counts rising edges of both mux outputs over a fixed window and compares the two counts to produce one response bit per pair.
- Assembles RESP_BITS bits into a response word consumed by the key generator feeding the AES core.

Parameters:
- N_RO, 16, number of ring oscillators per mux; must equal 2**SEL_W.
- SEL_W, 4, mux select width.
- CNT_W, 16, edge-counter width; counters saturate at 2**CNT_W-1.
- WINDOW, 1024, measurement window in clk cycles; must be 1 or more.
- SETTLE, 8, cycles between select change and count start; must be 1 or more.
- RESP_BITS, 8, response bits per run; must be at most N_RO/2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a run; ignored while busy
- challenge  in  SEL_W  XOR mask applied to pair indices; sampled on accepted start
- ro_a  in  1  output of mux A (asynchronous oscillation)
- ro_b  in  1  output of mux B (asynchronous oscillation)
- sel_a  out  SEL_W  select for mux A
- sel_b  out  SEL_W  select for mux B
- ro_en  out  1  ring-oscillator enable
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when response is valid
- response  out  RESP_BITS  response word; bit i comes from pair i
- tie  out  1  sticky flag: some pair produced equal counts in the last run

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, internal challenge register 0.
- Input synchronisation: ro_a and ro_b each pass through a 2-flop synchroniser, then a rising-edge detector. A counter increments on each detected edge while in COUNT and saturates at its maximum.
- Pair selection for index i: sel_a = (2i) XOR chal_q, sel_b = (2i+1) XOR chal_q. The two selects always differ.
- State IDLE:
  - busy=0, ro_en=0.
  - On start: latch challenge, clear response and tie, set i=0, go to SETTLE.
  - busy rises the cycle after start.
- State SETTLE:
  - ro_en=1, selects driven for pair i, counters held at 0.
  - Stays exactly SETTLE cycles, then goes to COUNT.
- State COUNT:
  - Counters enabled for exactly WINDOW cycles, then go to COMPARE.
- State COMPARE (1 cycle):
  - response[i] = (cnt_a > cnt_b).
  - If cnt_a == cnt_b, the bit is 0 and tie is set.
  - Counters are cleared.
  - If i == RESP_BITS-1, go to DONE; otherwise increment i and go to SETTLE.
- State DONE (1 cycle):
  - done=1, ro_en=0, then go to IDLE.
  - response and tie hold until the next accepted start.
- Latency:
  - start to done = 1 + RESP_BITS*(SETTLE+WINDOW+1) + 1 cycles.
  - With defaults: 1 + 8*1033 + 1 = 8266.
- Boundaries:
  - start while busy is ignored; challenge is not re-sampled.
  - start in the same cycle as done is ignored; start is accepted in IDLE only.
  - Reset mid-run returns immediately to IDLE with all outputs 0. No partial response is retained.
  - A saturated counter keeps its maximum value; if both saturate, the pair counts as a tie.
  - Selects hold their last value in IDLE.

Optional Feature:
- Macro: RO_PUF_MAJORITY_EN.
- Defined:
  - Each pair is measured 3 times (SETTLE+COUNT+COMPARE repeated).
  - response[i] is the majority of the 3 comparison bits.
  - tie is set if any of the 3 measurements tied.
  - Latency becomes 1 + RESP_BITS*3*(SETTLE+WINDOW+1) + 1 cycles.
- Undefined: single measurement per pair, as above.

Decomposition:
- Package ropuf_pkg holds:
  - the state enum (IDLE, SETTLE, COUNT, COMPARE, DONE);
  - default constants for SEL_W, CNT_W, WINDOW, SETTLE, RESP_BITS;
  - the measurement-repeat constant (1 or 3, chosen by the macro).
- Sub-module ro_edge_counter: 2-flop synchroniser, edge detector and saturating counter, with enable and clear inputs. Instantiated twice, for A and B.

Test Plan:
- Reset, then start with challenge=0 and ro_a toggling faster than ro_b for every pair -> selects step (0,1), (2,3) ... (14,15); done after exactly 8266 cycles; response=8'hFF; tie=0.
- challenge=4'h5 with ro_b faster than ro_a -> first pair sel_a=5, sel_b=4; response=8'h00.
- Equal frequencies on pair 3 only, ro_a faster elsewhere -> response=8'hF7; tie=1.
- Assert start at cycle 100 of a run -> ignored; done still at 8266 cycles after the original start.
- Assert rst during COUNT of pair 2 -> outputs immediately 0, busy=0, response=0; a subsequent start runs a complete sequence.
- With RO_PUF_MAJORITY_EN defined and a noise model flipping one of three comparisons on pair 0 -> majority bit correct; done after 1 + 8*3*1033 + 1 = 24794 cycles.
